// File: rtl/phase_accum.sv
// Phase accumulator for the sine lookup stage: handshaked frequency words,
// jump or glide to target, gate run/hold, retrigger and hard sync per sample tick.
module phase_accum #(
   parameter int unsigned PHASE_W     = 21,
   parameter int unsigned SAMPLE_DIV  = 1,
   parameter int unsigned GLIDE_SHIFT = 8,
   parameter bit          RETRIG      = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               freq_valid,
   input  logic [PHASE_W-1:0] freq_word,
   output logic               freq_ready,
   input  logic               glide_en,
   input  logic               gate,
   input  logic               sync_in,
   output logic               sample_en,
   output logic [PHASE_W-1:0] phase_out,
   output logic               wrap
);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_RUN,
      ST_GLIDE
   } state_e;

   localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

   state_e             state_q, state_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [PHASE_W-1:0] cur_q, cur_d;
   logic [PHASE_W-1:0] tgt_q, tgt_d;
   logic               rdy_q, rdy_d;
   logic               se_q, se_d;
   logic               wrap_q, wrap_d;
   logic               gate_q, gate_d;

   logic               tick;
   logic               accept;
   logic               gate_rise;
   logic               acc;
   logic               gliding;
   logic [PHASE_W:0]   sum;
   logic signed [PHASE_W:0] diff;
   logic signed [PHASE_W:0] step;

   always_comb begin
      tick      = (cnt_q == DIV_LAST);
      accept    = freq_valid & rdy_q;
      gate_rise = gate & ~gate_q;
      acc       = gate & (state_q != ST_HOLD);
      gliding   = glide_en & (cur_q != tgt_q);
      sum       = {1'b0, phase_q} + {1'b0, cur_q};
      diff      = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
      step      = diff >>> GLIDE_SHIFT;
      // small differences would stall the glide; always move at least one lsb
      if (step == '0 && diff != '0) begin
         step = diff[PHASE_W] ? '1 : {{PHASE_W{1'b0}}, 1'b1};
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cur_d   = cur_q;
      gate_d  = gate_q;
      cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
      tgt_d   = accept ? freq_word : tgt_q;
      rdy_d   = ~accept;
      se_d    = tick;
      wrap_d  = 1'b0;
      if (tick) begin
         gate_d = gate;
         cur_d  = gliding ? cur_q + step[PHASE_W-1:0] : tgt_q;
         if (!gate) begin
            state_d = ST_HOLD;
         end else if (gliding) begin
            state_d = ST_GLIDE;
         end else begin
            state_d = ST_RUN;
         end
         if (sync_in) begin
            phase_d = '0;
         end else if (RETRIG && gate_rise) begin
            phase_d = '0;
         end else if (acc) begin
            phase_d = sum[PHASE_W-1:0];
            wrap_d  = sum[PHASE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         phase_q <= '0;
         cur_q   <= '0;
         tgt_q   <= '0;
         rdy_q   <= 1'b0;
         se_q    <= 1'b0;
         wrap_q  <= 1'b0;
         gate_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         rdy_q   <= rdy_d;
         se_q    <= se_d;
         wrap_q  <= wrap_d;
         gate_q  <= gate_d;
      end
   end

   assign freq_ready = rdy_q;
   assign sample_en  = se_q;
   assign phase_out  = phase_q;
   assign wrap       = wrap_q;

endmodule

// File: tb/tb_phase_accum.sv
// Bench for phase_accum: scoreboard on the SAMPLE_DIV=1 instance,
// direct checks on a SAMPLE_DIV=4 instance.
module tb_phase_accum;

   logic        clk;
   logic        rst_n, freq_valid, glide_en, gate, sync_in;
   logic [20:0] freq_word;
   logic        freq_ready, sample_en, wrap;
   logic [20:0] phase_out;

   logic        rst2_n, fv2, ge2, g2, sy2;
   logic [20:0] fw2;
   logic        fr2, se2, wr2;
   logic [20:0] ph2_o;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        chk;
      logic [20:0] ph;
      logic        w;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   nsamp = 0;

   phase_accum u_dut (
      .clk(clk), .rst_n(rst_n),
      .freq_valid(freq_valid), .freq_word(freq_word),
      .freq_ready(freq_ready), .glide_en(glide_en),
      .gate(gate), .sync_in(sync_in),
      .sample_en(sample_en), .phase_out(phase_out),
      .wrap(wrap)
   );

   phase_accum #(.SAMPLE_DIV(4)) u_div4 (
      .clk(clk), .rst_n(rst2_n),
      .freq_valid(fv2), .freq_word(fw2),
      .freq_ready(fr2), .glide_en(ge2),
      .gate(g2), .sync_in(sy2),
      .sample_en(se2), .phase_out(ph2_o),
      .wrap(wr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // monitor: one scoreboard entry per sample pulse
   always @(negedge clk) begin
      if (sample_en) begin
         nsamp++;
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: sample %0d phase=%0d, none expected",
                     nsamp, phase_out);
         end else begin
            e = sbq.pop_front();
            if (e.chk) begin
               total++;
               if (phase_out !== e.ph || wrap !== e.w) begin
                  bad++;
                  $display("FAIL sb_sample%0d: got phase=%0d wrap=%0d, expected phase=%0d wrap=%0d",
                           nsamp, phase_out, wrap, e.ph, e.w);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tk(input logic c, input logic [20:0] ph, input logic w);
      exp_t x;
      x = '{chk: c, ph: ph, w: w};
      sbq.push_back(x);
      @(posedge clk);
      #1;
   endtask

   logic [11:0] se_v, rdy_v;
   logic [20:0] ph2 [3];
   int          n2, acc2;
   logic        wr2_seen;

   initial begin
      rst_n = 0; freq_valid = 0; freq_word = '0;
      glide_en = 0; gate = 0; sync_in = 0;
      rst2_n = 0; fv2 = 0; fw2 = '0; ge2 = 0; g2 = 0; sy2 = 0;
      se_v = '0; rdy_v = '0; n2 = 0; acc2 = 0; wr2_seen = 0;
      for (int i = 0; i < 3; i++) ph2[i] = '0;
      repeat (3) @(posedge clk);
      #1;

      // divided sample rate and 3-cycle valid on the SAMPLE_DIV=4 instance
      fv2 = 1; fw2 = 21'd100; g2 = 1; rst2_n = 1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         se_v[k-1]  = se2;
         rdy_v[k-1] = fr2;
         if (se2) begin
            if (n2 < 3) ph2[n2] = ph2_o;
            wr2_seen = wr2_seen | wr2;
            n2++;
         end
         if (k == 3) fv2 = 0;
         if (fv2 && fr2) acc2++;
      end
      chk("div4_sample_en", {20'd0, se_v}, 32'h888);
      chk("div4_ready", {20'd0, rdy_v}, 32'hFFD);
      chk("div4_accepts", acc2, 1);
      chk("div4_nsamples", n2, 3);
      chk("div4_ph0", {11'd0, ph2[0]}, 0);
      chk("div4_ph1", {11'd0, ph2[1]}, 100);
      chk("div4_ph2", {11'd0, ph2[2]}, 200);
      chk("div4_wrap", {31'd0, wr2_seen}, 0);

      // reset state of main instance
      chk("rst_phase", {11'd0, phase_out}, 0);
      chk("rst_sample_en", {31'd0, sample_en}, 0);
      chk("rst_ready", {31'd0, freq_ready}, 0);
      chk("rst_wrap", {31'd0, wrap}, 0);

      // handshake, retrigger, steady run at 1000
      rst_n = 1; freq_valid = 1; freq_word = 21'd1000;
      tk(1, 0, 0);
      chk("ready_after_rst", {31'd0, freq_ready}, 1);
      tk(1, 0, 0);
      chk("ready_drop", {31'd0, freq_ready}, 0);
      freq_word = 21'd7777;
      tk(1, 0, 0);
      chk("ready_back", {31'd0, freq_ready}, 1);
      freq_valid = 0; gate = 1;
      tk(1, 0, 0);
      tk(1, 1000, 0);
      tk(1, 2000, 0);
      tk(1, 3000, 0);

      // jump to 1046000 and back to 1000 to land on 2097000
      freq_valid = 1; freq_word = 21'd1046000;
      tk(1, 4000, 0);
      freq_valid = 0;
      tk(1, 5000, 0);
      freq_valid = 1; freq_word = 21'd1000;
      tk(1, 1051000, 0);
      freq_valid = 0;
      tk(1, 2097000, 0);
      tk(1, 848, 1);
      tk(1, 1848, 0);

      // zero increment, sync, then glide 0 -> 4096
      freq_valid = 1; freq_word = 21'd0;
      tk(1, 2848, 0);
      freq_valid = 0;
      tk(1, 3848, 0);
      sync_in = 1;
      tk(1, 0, 0);
      sync_in = 0; freq_valid = 1; freq_word = 21'd4096; glide_en = 1;
      tk(1, 0, 0);
      freq_valid = 0;
      tk(1, 0, 0);
      tk(1, 16, 0);
      tk(1, 47, 0);
      tk(1, 93, 0);
      tk(1, 154, 0);
      repeat (1600) tk(0, 0, 0);
      sync_in = 1;
      tk(1, 0, 0);
      sync_in = 0;
      tk(1, 4096, 0);
      tk(1, 8192, 0);

      // glide toward 8192, then drop glide_en -> jump
      freq_valid = 1; freq_word = 21'd8192;
      tk(1, 12288, 0);
      freq_valid = 0;
      tk(1, 16384, 0);
      glide_en = 0;
      tk(1, 20496, 0);
      tk(1, 28688, 0);
      tk(1, 36880, 0);

      // gate hold, retrigger, sync in hold and on gate rise
      gate = 0;
      tk(1, 36880, 0);
      tk(1, 36880, 0);
      gate = 1;
      tk(1, 0, 0);
      tk(1, 8192, 0);
      gate = 0;
      tk(1, 8192, 0);
      sync_in = 1;
      tk(1, 0, 0);
      sync_in = 0;
      tk(1, 0, 0);
      gate = 1; sync_in = 1;
      tk(1, 0, 0);
      sync_in = 0;
      tk(1, 8192, 0);

      // sync on a tick that would otherwise overflow: no wrap
      freq_valid = 1; freq_word = 21'd2090000;
      tk(1, 16384, 0);
      freq_valid = 0;
      tk(1, 24576, 0);
      tk(1, 17424, 1);
      sync_in = 1;
      tk(1, 0, 0);
      sync_in = 0;
      tk(1, 2090000, 0);

      // start a glide down, then reset mid-glide with a word pending
      glide_en = 1; freq_valid = 1; freq_word = 21'd4096;
      tk(1, 2082848, 1);
      freq_valid = 0;
      tk(1, 2075696, 1);
      freq_valid = 1; freq_word = 21'd12345; rst_n = 0;
      @(posedge clk);
      #1;
      chk("midrst_phase", {11'd0, phase_out}, 0);
      chk("midrst_ready", {31'd0, freq_ready}, 0);
      chk("midrst_sample_en", {31'd0, sample_en}, 0);
      chk("midrst_wrap", {31'd0, wrap}, 0);
      freq_valid = 0; glide_en = 0; gate = 1; rst_n = 1;
      tk(1, 0, 0);
      chk("midrst_ready_back", {31'd0, freq_ready}, 1);
      tk(1, 0, 0);
      tk(1, 0, 0);

      @(negedge clk);
      #1;
      chk("sb_drained", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
